// File: rtl/mp_addsub_seq.sv
// Multi-precision add/subtract sequencer: one shared 32-bit adder processes
// one word per clock, LSW first, with the carry chained through a register.

module cls_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [16:0] lo_s;
  logic [16:0] hi0_s;
  logic [16:0] hi1_s;

  // Carry-select: both upper-half results are ready before the lower carry.
  always_comb begin
    lo_s  = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, cin};
    hi0_s = {1'b0, a[31:16]} + {1'b0, b[31:16]};
    hi1_s = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;
    if (lo_s[16]) begin
      sum  = {hi1_s[15:0], lo_s[15:0]};
      cout = hi1_s[16];
    end else begin
      sum  = {hi0_s[15:0], lo_s[15:0]};
      cout = hi0_s[16];
    end
  end
endmodule

module mp_addsub_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                op,
  input  logic [32*WORDS-1:0] a,
  input  logic [32*WORDS-1:0] b,
  output logic [32*WORDS-1:0] result,
  output logic                carry_out,
  output logic                overflow,
  output logic                busy,
  output logic                done
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                   state_r, state_n;
  logic [IW-1:0]            idx_r;
  logic                     carry_r;
  logic                     op_r;
  logic [WORDS-1:0][31:0]   a_r;
  logic [WORDS-1:0][31:0]   b_r;
  logic [WORDS-1:0][31:0]   result_r;
  logic                     carry_out_r;
  logic                     overflow_r;
  logic                     busy_r;
  logic                     done_r;

  logic [31:0]              a_word_s;
  logic [31:0]              b_word_s;
  logic [31:0]              sum_s;
  logic                     cout_s;
  logic                     last_s;

  // Subtraction is A + ~B + 1; the +1 enters through the preloaded carry.
  always_comb begin
    a_word_s = a_r[idx_r];
    b_word_s = b_r[idx_r] ^ {32{op_r}};
    last_s   = (idx_r == IW'(WORDS - 1));
  end

  cls_32bit u_adder (
    .a    (a_word_s),
    .b    (b_word_s),
    .cin  (carry_r),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (start) state_n = RUN;  else state_n = IDLE;
      RUN:     if (last_s) state_n = DONE; else state_n = RUN;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      carry_r     <= 1'b0;
      op_r        <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      result_r    <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_r  <= (state_n != IDLE);
      done_r  <= (state_n == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            op_r    <= op;
            carry_r <= op;
            idx_r   <= '0;
          end
        end
        RUN: begin
          result_r[idx_r] <= sum_s;
          carry_r         <= cout_s;
          if (last_s) begin
            carry_out_r <= cout_s;
            overflow_r  <= (a_word_s[31] == b_word_s[31]) && (sum_s[31] != a_word_s[31]);
            idx_r       <= '0;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        DONE:    idx_r <= '0;
        default: idx_r <= '0;
      endcase
    end
  end

  assign result    = result_r;
  assign carry_out = carry_out_r;
  assign overflow  = overflow_r;
  assign busy      = busy_r;
  assign done      = done_r;
endmodule

// File: tb/tb_mp_addsub_seq.sv
// Directed table-driven bench for mp_addsub_seq (WORDS=4) plus corner sequences.

module tb_mp_addsub_seq;
  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result;
  logic         carry_out, overflow, busy, done;

  int total_cnt = 0;
  int pass_cnt  = 0;

  mp_addsub_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .result(result), .carry_out(carry_out), .overflow(overflow),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Start one operation; optionally re-pulse start with junk in RUN and DONE.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic iop,
                        input bit repulse,
                        output logic [W-1:0] res, output logic co, output logic ov,
                        output int done_cnt, output int done_edge, output int busy_cnt);
    done_cnt = 0; done_edge = -1; busy_cnt = 0;
    res = 'x; co = 1'bx; ov = 1'bx;
    @(negedge clk);
    a = ia; b = ib; op = iop; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = '1; b = '1; op = ~iop;
    if (busy) busy_cnt++;
    for (int k = 1; k <= 12; k++) begin
      start = repulse && (k == 2 || k == 5);
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_edge = k;
        res = result; co = carry_out; ov = overflow;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_op(input string nm, input vec_t v, input bit repulse);
    logic [W-1:0] res;
    logic co, ov;
    int dc, de, bc;
    run_op(v.a, v.b, v.op, repulse, res, co, ov, dc, de, bc);
    chk({nm, " result"}, res, v.res);
    chk({nm, " carry_out"}, W'(co), W'(v.co));
    chk({nm, " overflow"}, W'(ov), W'(v.ov));
    chk({nm, " done_count"}, W'(dc), W'(1));
    chk({nm, " done_edge"}, W'(de), W'(WORDS));
    chk({nm, " busy_cycles"}, W'(bc), W'(WORDS + 1));
    chk({nm, " result_held"}, result, v.res);
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{1'b0, {W{1'b1}}, 128'd1, 128'd0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1,
                128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 128'd5, 128'd7, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 128'd7, 128'd5, 128'd2, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1,
                128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'd1,
                128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 128'h8000_0000_0000_0000_0000_0000_0000_0000,
                128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'd0, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1,
                128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0};

    #12;
    chk("reset result", result, '0);
    chk("reset flags", W'({carry_out, overflow, busy, done}), W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) check_op($sformatf("vec%0d", i), vecs[i], 1'b0);

    // Start re-pulsed in RUN and DONE must be ignored.
    rv = '{1'b0, 128'h1234_5678_0000_0001_FFFF_FFFF_0000_0010, 128'h1111_1111_0000_0002_0000_0001_0000_0020,
           128'h2345_6789_0000_0004_0000_0000_0000_0030, 1'b0, 1'b0};
    check_op("ignore_start", rv, 1'b1);

    // Reset with idx=2 in RUN aborts asynchronously.
    @(negedge clk);
    a = {W{1'b1}}; b = 128'd1; op = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset result", result, '0);
    chk("midrun_reset flags", W'({carry_out, overflow, busy, done}), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    rv = '{1'b0, 128'd3, 128'd4, 128'd7, 1'b0, 1'b0};
    check_op("after_reset", rv, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
